// File: rtl/nivel_classificador.sv
// nivel_classificador: validates ultrasonic distance readings, filters them with a 4-sample moving average and classifies the water level.
// Ports: clock/reset (async, active-low); analisa request + medida (mm) in;
//   medida_classificacao (001 baixa, 010 alta, 011 muito alta, 100 nao critica), fim_classificacao and
//   descartar_medida pulses, nivel (average level mm) and db_estado (FSM state) out.
// Optional macro NIVEL_HISTERESE_EN: adds a HIST-mm hysteresis band around every class boundary.
module nivel_classificador #(
  parameter int ALTURA_MM      = 1000,
  parameter int LIM_BAIXO      = 200,
  parameter int LIM_ALTO       = 700,
  parameter int LIM_MUITO_ALTO = 850,
  parameter int MAX_DELTA      = 100,
  parameter int MAX_DESCARTES  = 3,
  parameter int HIST           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        analisa,
  input  logic [11:0] medida,
  output logic [2:0]  medida_classificacao,
  output logic        fim_classificacao,
  output logic        descartar_medida,
  output logic [11:0] nivel,
  output logic [2:0]  db_estado
);
  localparam int CW = $clog2(MAX_DESCARTES + 1);
  localparam logic [11:0] ALT = 12'(ALTURA_MM);
  localparam logic [11:0] LB  = 12'(LIM_BAIXO);
  localparam logic [11:0] LA  = 12'(LIM_ALTO);
  localparam logic [11:0] LM  = 12'(LIM_MUITO_ALTO);
  localparam logic signed [12:0] MD = 13'(MAX_DELTA);
`ifdef NIVEL_HISTERESE_EN
  localparam logic [11:0] HB = 12'(HIST);
`else
  localparam logic [11:0] HB = 12'(HIST) & 12'd0;
`endif
  typedef enum logic [2:0] {
    IDLE = 3'd0, VALIDA = 3'd1, FILTRA = 3'd2, RESULTADO = 3'd3, DESCARTE = 3'd4, ESPERA = 3'd5
  } estado_t;
  estado_t state_q;
  logic analisa_q, hv_q;
  logic [11:0] med_q, nivel_q;
  logic [11:0] h_q [4];
  logic [CW-1:0] cnt_q;
  logic [2:0] cls_q;
  logic [11:0] nivel_inst, media_d, b1, b2, b3;
  logic [11:0] cand [4];
  logic [13:0] sum;
  logic signed [12:0] dlt;
  logic invalida, outlier, prefill;
  logic [2:0] cls_d;
  always_comb begin
    nivel_inst = ALT - med_q;
    invalida = med_q == 12'd0 || med_q > ALT;
    dlt = $signed({1'b0, nivel_inst}) - $signed({1'b0, nivel_q});
    outlier = hv_q && (dlt > MD || dlt < -MD) && cnt_q < CW'(MAX_DESCARTES);
    // empty history or a confirmed step change: fill every slot with the new level
    prefill = !hv_q || cnt_q == CW'(MAX_DESCARTES);
    cand[0] = nivel_inst;
    cand[1] = prefill ? nivel_inst : h_q[0];
    cand[2] = prefill ? nivel_inst : h_q[1];
    cand[3] = prefill ? nivel_inst : h_q[2];
    sum = 14'(cand[0]) + 14'(cand[1]) + 14'(cand[2]) + 14'(cand[3]);
    media_d = 12'(sum >> 2);
    // each boundary moves away from the current class; with HB=0 this is a plain compare
    b1 = !hv_q ? LB : cls_q == 3'b001 ? LB + HB : LB - HB;
    b2 = !hv_q ? LA : (cls_q == 3'b001 || cls_q == 3'b100) ? LA + HB : LA - HB;
    b3 = !hv_q ? LM : cls_q == 3'b011 ? LM - HB : LM + HB;
    cls_d = media_d < b1 ? 3'b001 : media_d >= b3 ? 3'b011 : media_d >= b2 ? 3'b010 : 3'b100;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      analisa_q <= 1'b0;
      hv_q      <= 1'b0;
      med_q     <= '0;
      nivel_q   <= '0;
      h_q       <= '{default: '0};
      cnt_q     <= '0;
      cls_q     <= '0;
    end else begin
      analisa_q <= analisa;
      case (state_q)
        IDLE: if (analisa && !analisa_q) begin
          med_q   <= medida;
          state_q <= VALIDA;
        end
        VALIDA: if (!analisa) state_q <= IDLE;
          else if (invalida) state_q <= DESCARTE;
          else if (outlier) begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= DESCARTE;
          end else state_q <= FILTRA;
        FILTRA: if (!analisa) state_q <= IDLE;
          else begin
            h_q     <= cand;
            nivel_q <= media_d;
            cls_q   <= cls_d;
            hv_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= RESULTADO;
          end
        RESULTADO, DESCARTE: state_q <= ESPERA;
        ESPERA: if (!analisa) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign medida_classificacao = cls_q;
  assign nivel = nivel_q;
  assign fim_classificacao = state_q == RESULTADO;
  assign descartar_medida = state_q == DESCARTE;
  assign db_estado = state_q;
endmodule
